// File: rtl/mvm_pkg.sv
// Shared types and sizing helpers for the mvm4 host-side feeder.
package mvm_pkg;

    typedef enum logic [2:0] {LOAD, START, SEND, WAIT, COLLECT, DRAIN} state_t;

    localparam int DEF_MAT_SCALE    = 4;
    localparam int DEF_INPUT_WIDTH  = 8;
    localparam int DEF_OUTPUT_WIDTH = 16;

    function automatic int job_len(input int n);
        return n * n + n;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mvm_feeder_buf.sv
// Small register file: one synchronous write port, one combinational read port.
module feeder_buf
    import mvm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 20,
    localparam int AW   = idx_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic signed [WIDTH-1:0] wdata,
    input  logic [AW-1:0]           raddr,
    output logic signed [WIDTH-1:0] rdata
);

    logic signed [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mvm_feeder.sv
// Buffers one matrix-vector job, replays it gap-free into the mvm4 multiplier,
// then captures the N results and streams them out under valid/ready.
module mvm_feeder
    import mvm_pkg::*;
#(
    parameter int MAT_SCALE    = DEF_MAT_SCALE,
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int RD_LAT       = 0,
    parameter int JOB_LEN      = job_len(MAT_SCALE)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic signed [INPUT_WIDTH-1:0]  in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic signed [OUTPUT_WIDTH-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           mvm_start,
    output logic signed [INPUT_WIDTH-1:0]  mvm_data_in,
    input  logic                           mvm_done,
    input  logic signed [OUTPUT_WIDTH-1:0] mvm_data_out,
    output logic                           busy
);

    localparam int CW = idx_w(JOB_LEN);
    localparam int YW = idx_w(MAT_SCALE);
    localparam int DW = idx_w(RD_LAT + 1);
    localparam logic [CW-1:0] LAST_K  = CW'(JOB_LEN - 1);
    localparam logic [YW-1:0] LAST_Y  = YW'(MAT_SCALE - 1);
    localparam logic [DW-1:0] DLY_MAX = DW'(RD_LAT);

    state_t                         state;
    logic [CW-1:0]                  cnt;
    logic [YW-1:0]                  yi;
    logic [DW-1:0]                  dly;
    logic [CW-1:0]                  jb_raddr;
    logic signed [INPUT_WIDTH-1:0]  jb_rdata;
    logic signed [OUTPUT_WIDTH-1:0] yb_rdata;
    logic                           jb_we;
    logic                           cap_now;

    assign in_ready  = (state == LOAD);
    assign busy      = (state != LOAD);
    assign mvm_start = (state == START);
    assign out_valid = (state == DRAIN);
    assign out_data  = (state == DRAIN) ? yb_rdata : '0;

    assign jb_we = (state == LOAD) && in_valid;
    // Prefetch the element that goes out next cycle so the stream has no bubbles.
    assign jb_raddr = (state == SEND && cnt != LAST_K) ? cnt + 1'b1 : '0;

    // With zero read latency y[0] is already on the bus in the done cycle itself.
    assign cap_now = (state == WAIT && mvm_done && RD_LAT == 0) ||
                     (state == COLLECT && dly == DLY_MAX);

    feeder_buf #(.WIDTH(INPUT_WIDTH), .DEPTH(JOB_LEN)) u_job_buf (
        .clk   (clk),
        .we    (jb_we),
        .waddr (cnt),
        .wdata (in_data),
        .raddr (jb_raddr),
        .rdata (jb_rdata)
    );

    feeder_buf #(.WIDTH(OUTPUT_WIDTH), .DEPTH(MAT_SCALE)) u_res_buf (
        .clk   (clk),
        .we    (cap_now),
        .waddr (yi),
        .wdata (mvm_data_out),
        .raddr (yi),
        .rdata (yb_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LOAD;
            cnt         <= '0;
            yi          <= '0;
            dly         <= '0;
            mvm_data_in <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (cnt == LAST_K) begin
                            cnt   <= '0;
                            state <= START;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                START: begin
                    mvm_data_in <= jb_rdata;
                    state       <= SEND;
                end
                SEND: begin
                    if (cnt == LAST_K) begin
                        cnt         <= '0;
                        mvm_data_in <= '0;
                        state       <= WAIT;
                    end else begin
                        cnt         <= cnt + 1'b1;
                        mvm_data_in <= jb_rdata;
                    end
                end
                WAIT: begin
                    if (mvm_done) begin
                        dly   <= (RD_LAT == 0) ? '0 : DW'(1);
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (dly != DLY_MAX) dly <= dly + 1'b1;
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (yi == LAST_Y) begin
                            yi    <= '0;
                            state <= LOAD;
                        end else begin
                            yi <= yi + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase

            // Result capture walks yi; the last capture hands over to DRAIN.
            if (cap_now) begin
                if (yi == LAST_Y) begin
                    yi    <= '0;
                    state <= DRAIN;
                end else begin
                    yi <= yi + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/mvm_feeder.md
Name: mvm_feeder

Overview:
- Host-side driver for the 4x4 matrix-vector multiplier (mvm4_part2 interface).
- Accepts one job as a valid/ready element stream: N*N matrix elements in row-major order, then N vector elements. Buffers the whole job.
- Issues the multiplier's start pulse, then replays the job one element per cycle with no gaps, as the multiplier requires.
- Captures the N results after the done pulse and returns them on a valid/ready output stream.

Parameters:
- MAT_SCALE, 4: matrix dimension N.
- INPUT_WIDTH, 8: element width, signed.
- OUTPUT_WIDTH, 16: result width, signed.
- RD_LAT, 0: cycles from the mvm_done-high cycle to y[0] valid on mvm_data_out.
- JOB_LEN, MAT_SCALE*MAT_SCALE+MAT_SCALE: derived; elements per job.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- in_data, input, INPUT_WIDTH: job element, signed.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: block can accept an element.
- out_data, output, OUTPUT_WIDTH: result element y[i], signed.
- out_valid, output, 1: out_data valid.
- out_ready, input, 1: consumer accepts out_data.
- mvm_start, output, 1: start pulse to multiplier.
- mvm_data_in, output, INPUT_WIDTH: element stream to multiplier.
- mvm_done, input, 1: multiplier done pulse.
- mvm_data_out, input, OUTPUT_WIDTH: multiplier result stream.
- busy, output, 1: high in any state except LOAD.

Behaviour:
- Reset: synchronous, active-high, clock clk. All outputs are registered or decoded from state.
- Reset values: state=LOAD, counters=0, in_ready=1, out_valid=0, out_data=0, mvm_start=0, mvm_data_in=0, busy=0.
- Reset at any point (mid-SEND, WAIT, DRAIN) abandons the job. Buffers are not cleared, but contents are never re-emitted.
- The environment resets the multiplier together with this block.
- LOAD:
  - in_ready=1.
  - A transfer occurs when in_valid&in_ready at a posedge; the element is written to buf[cnt] and cnt increments.
  - Gaps on in_valid are allowed.
  - On the transfer with cnt==JOB_LEN-1: cnt<=0, go to START. in_ready drops in the following cycle, so no extra element is taken.
- START: mvm_start=1 for exactly one cycle (cycle t). Go to SEND.
- SEND:
  - mvm_data_in=buf[k] in cycle t+1+k, for k=0..JOB_LEN-1, with no gaps.
  - mvm_data_in is registered, and the element is presented in its cycle.
  - After k=JOB_LEN-1: mvm_data_in<=0, go to WAIT.
- WAIT: on mvm_done=1 in cycle d, go to COLLECT.
- COLLECT:
  - Capture mvm_data_out into ybuf[i] in cycle d+RD_LAT+i, for i=0..N-1.
  - A cycle counter spans the RD_LAT delay.
  - After i=N-1, go to DRAIN.
- DRAIN:
  - out_valid=1, out_data=ybuf[j].
  - On out_valid&out_ready, j increments.
  - out_data and out_valid hold stable while out_ready=0.
  - On acceptance of j=N-1: out_valid<=0, go to LOAD.
  - The next job may begin loading in the following cycle.
- mvm_done outside WAIT is ignored; no state change and no capture.
- mvm_start never asserts outside START, so there is at most one job in flight.
- No arithmetic is performed. Result values pass through bit-exact, including wrap-around from the multiplier.
- No timeout in WAIT. The block stays there until mvm_done or reset.
- Counter widths: $clog2(JOB_LEN) for the job counter, $clog2(N) for y indices, $clog2(RD_LAT+1) or at least 1 bit for the delay counter.

Decomposition:
- Package mvm_pkg:
  - state enum {LOAD, START, SEND, WAIT, COLLECT, DRAIN}.
  - Default MAT_SCALE, INPUT_WIDTH, OUTPUT_WIDTH constants.
  - JOB_LEN function.
- Sub-module feeder_buf: parameterised register file (WIDTH, DEPTH) with one synchronous write port and one combinational read port.
  - Instantiated twice: job buffer (INPUT_WIDTH x JOB_LEN) and result buffer (OUTPUT_WIDTH x N).
- FSM and counters live in mvm_feeder.

Test Plan:
- Identity job: A=I, x=1,2,3,4, in_valid held high.
  - Response: mvm_start pulses once, 20 contiguous mvm_data_in cycles; out stream 1,2,3,4; busy drops after the 4th accept.
- Gappy input: same job with in_valid toggled 50%, plus 2 extra elements offered after the 20th.
  - Response: in_ready=0 after the 20th transfer; the extra elements are not consumed until DRAIN completes.
- Overflow passthrough: A all -128, x all -128.
  - Response: each y=65536 wraps to 0; out 0,0,0,0. A=all 1, x=127 gives 508 four times.
- Backpressure: out_ready low for 5 cycles between each element.
  - Response: out_data stable while stalled; exactly 4 accepts; no duplicates or drops.
- Stray done and reset: mvm_done pulsed during LOAD has no effect; reset asserted at SEND k=7.
  - Response: all outputs at reset values next cycle; a fresh job afterwards completes correctly.
- Back-to-back jobs: two jobs with distinct data, out_ready=1.
  - Response: two start pulses; the second start occurs only after the 4th result of job 1 is accepted; results match a reference model.
